clk_int_div_dyn: RTL and testbench
==================================

Name: clk_int_div_dyn

Overview:
Runtime-programmable integer clock divider for peripheral and IP clock generation. It is the successor to the fixed and simple dividers. The ratio is loaded over a valid/ready handshake and applied only at an output-period boundary, so the output never glitches. It also provides enable-controlled start/stop at period boundaries and an optional 50% duty cycle for odd ratios.

Parameters:
DIV_VALUE_WIDTH, 8, width of the division ratio, the counter and clk_cnt_o.
DIV_RESET_VALUE, 2, active ratio after reset; values below 2 are clamped to 2.

Ports:
clk_i  input  1  source clock; all state is on posedge, except the optional negedge flop.
rst_i  input  1  asynchronous, active-high reset.
en_i  input  1  run request; 1 = generate clock, 0 = stop at the next period end.
div_i  input  DIV_VALUE_WIDTH  requested ratio D (clk_o = clk_i / D); 0 and 1 are clamped to 2.
div_valid_i  input  1  div_i valid.
div_ready_o  output  1  no update pending; the handshake completes on valid & ready at a posedge.
div_done_o  output  1  one-cycle pulse: the pending ratio became active.
clk_cnt_o  output  DIV_VALUE_WIDTH  current phase counter, range 0..D-1.
clk_o  output  1  divided clock, registered (glitch-free).

Behaviour:
- Reset (asynchronous, rst_i=1):
  - clk_o=0, clk_cnt_o=0, div_ready_o=1, div_done_o=0.
  - running=0, pending=0.
  - active D = max(DIV_RESET_VALUE, 2).
- Internal state: active D, pending ratio plus pending flag, running flag, counter cnt_q.
  - H = D>>1 (high-phase length).
  - clk_o is a flop loaded with (running_next && cnt_next < H), so clk_o=1 iff running and cnt_q<H.
- Counting while running: at each posedge, cnt_q <= (cnt_q==D-1) ? 0 : cnt_q+1.
- Period end: the posedge where running=1 and cnt_q==D-1.
- Start: idle and en_i=1 at a posedge -> running<=1, cnt_q<=0, clk_o<=1. Latency is one clk_i cycle from the en_i sample.
- Stop: running and en_i=0 -> the current period always completes. At period end, running<=0, cnt_q<=0, clk_o stays 0.
  - en_i re-asserted before period end cancels the stop; there is no gap.
- Handshake:
  - On valid & ready, the clamped div_i is stored as pending and div_ready_o<=0.
  - While div_ready_o=0, div_valid_i is ignored and div_i is don't-care after capture.
- Apply:
  - Pending is applied at the first period end, or at the next posedge if not running.
  - At that edge: active D<=pending, cnt_q<=0, div_ready_o<=1, div_done_o<=1 for exactly one cycle.
  - The new ratio governs the period starting at that edge.
- Simultaneous events:
  - Apply and stop at the same period end: both take effect; the new D is used on the next start.
  - A new valid on the same edge that div_ready_o returns to 1 is not accepted. Acceptance needs ready=1 sampled at the edge.
- Width rule: D ranges 2..2^DIV_VALUE_WIDTH-1; the counter never exceeds D-1, so no overflow is possible.
- Reset mid-operation: clk_o drops asynchronously to 0 and any pending update is discarded.

Optional Feature:
Macro CLK_INT_DIV_DYN_ODD_DUTY50_EN.
- Defined:
  - A negedge flop samples the posedge clk_o flop, reset 0.
  - When D is odd, clk_o = pos_q | neg_q. This gives a high phase of H+0.5 and a low phase of H+0.5 cycles, i.e. exactly 50% duty.
  - When D is even, neg_q is not ORed in.
- Not defined:
  - No negedge logic.
  - Odd D gives high H cycles and low H+1 cycles.

Test Plan:
1. Reset release with DIV_RESET_VALUE=2, en_i=1 -> clk_o starts one cycle later as 1,0,1,0 (period 2); clk_cnt_o alternates 0,1; div_ready_o=1.
2. Running at D=2, handshake div_i=5 while cnt=0 -> div_ready_o=0 next cycle; applied at the cnt=1 end edge; div_done_o pulses one cycle; then clk_o is high 2 and low 3 cycles repeatedly, and div_ready_o=1.
3. D=6 running, en_i dropped at cnt=1 -> clk_o high through cnt 2, low through cnt 5, then stays 0 with clk_cnt_o=0; en_i=1 again -> new period begins one cycle later.
4. div_i=0 and div_i=1 handshakes -> each behaves as D=2; a second div_valid_i held high while div_ready_o=0 is not captured (check with a distinct value, 9).
5. With the macro, D=5 -> clk_o high 2.5 and low 2.5 cycles, measured edge to edge. Without it -> high 2, low 3.
6. rst_i asserted during the high phase with an update pending -> clk_o=0 immediately (asynchronous), div_ready_o=1, active D=DIV_RESET_VALUE, no div_done_o pulse.

Source files
------------

// File: rtl/clk_int_div_dyn.sv
// -----------------------------------------------------------------------------
// clk_int_div_dyn
//
// Runtime-programmable integer clock divider. Produces clk_o = clk_i / D, where
// D is loaded over a valid/ready handshake and only takes effect at an output
// period boundary (or immediately while stopped), so clk_o never glitches.
// Starting and stopping via en_i also happen on period boundaries: a stop
// request always lets the current period finish.
//
// Optional feature (compile-time macro CLK_INT_DIV_DYN_ODD_DUTY50_EN):
//   When defined, an extra negedge flop stretches the high phase by half a
//   source cycle for odd D, giving an exact 50% duty cycle. When undefined,
//   odd D gives H high cycles and H+1 low cycles (H = D>>1).
//
// Parameters:
//   DIV_VALUE_WIDTH  width of the ratio, the phase counter and clk_cnt_o
//   DIV_RESET_VALUE  ratio active after reset (values below 2 become 2)
//
// Ports:
//   clk_i        source clock (posedge logic, plus optional negedge flop)
//   rst_i        asynchronous active-high reset
//   en_i         run request; 0 stops the output at the next period end
//   div_i        requested ratio; 0 and 1 are treated as 2
//   div_valid_i  div_i is valid
//   div_ready_o  no update pending; handshake completes on valid & ready
//   div_done_o   one-cycle pulse when the pending ratio becomes active
//   clk_cnt_o    current phase counter, 0..D-1
//   clk_o        divided clock
// -----------------------------------------------------------------------------
module clk_int_div_dyn #(
  parameter int DIV_VALUE_WIDTH = 8,
  parameter int DIV_RESET_VALUE = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [DIV_VALUE_WIDTH-1:0] div_i,
  input  logic                       div_valid_i,
  output logic                       div_ready_o,
  output logic                       div_done_o,
  output logic [DIV_VALUE_WIDTH-1:0] clk_cnt_o,
  output logic                       clk_o
);

  localparam int W = DIV_VALUE_WIDTH;
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] MIN_DIV   = W'(2);
  localparam logic [W-1:0] RESET_DIV = (DIV_RESET_VALUE < 2) ? MIN_DIV : W'(DIV_RESET_VALUE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_next;
  logic [W-1:0] div_q;
  logic [W-1:0] div_next;
  logic [W-1:0] pend_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_next;
  logic         ready_q;
  logic         done_q;
  logic         clk_q;
  logic         clk_next;
  logic         period_end;
  logic         accept;
  logic         apply;

  // Ratios below 2 cannot produce a toggling output, so they are raised to 2.
  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

  // Next-state decode. A pending ratio is applied on the same edge that
  // restarts the counter, and the new ratio already decides the first
  // high phase of the period that begins there.
  always_comb begin
    period_end = (state_q == RUN) && (cnt_q == (div_q - ONE));
    accept     = div_valid_i && ready_q;
    apply      = !ready_q && (period_end || (state_q == IDLE));

    state_next = state_q;
    case (state_q)
      IDLE:    if (en_i) state_next = RUN;
      RUN:     if (period_end && !en_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    cnt_next = '0;
    if ((state_q == RUN) && !period_end) begin
      cnt_next = cnt_q + ONE;
    end

    div_next = apply ? pend_q : div_q;
    clk_next = (state_next == RUN) && (cnt_next < (div_next >> 1));
  end

  // Accept and apply are mutually exclusive: accept needs ready high while
  // apply needs an update pending (ready low). A valid arriving on the edge
  // where ready returns high therefore sees ready=0 and is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= RESET_DIV;
      pend_q  <= RESET_DIV;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      div_q   <= div_next;
      cnt_q   <= cnt_next;
      clk_q   <= clk_next;
      done_q  <= apply;
      if (accept) begin
        pend_q  <= clamp_div(div_i);
        ready_q <= 1'b0;
      end else if (apply) begin
        ready_q <= 1'b1;
      end
    end
  end

`ifdef CLK_INT_DIV_DYN_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy of the posedge output. ORing it in for odd D
  // extends the high phase by half a source cycle. At every ratio change
  // clk_q has just been low for a whole cycle, so neg_q is 0 and the
  // switch between ORed and plain output cannot glitch.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_q;
    end
  end

  assign clk_o = clk_q | (div_q[0] & neg_q);
`else
  assign clk_o = clk_q;
`endif

  assign div_ready_o = ready_q;
  assign div_done_o  = done_q;
  assign clk_cnt_o   = cnt_q;

endmodule

// File: tb/tb_clk_int_div_dyn.sv
// -----------------------------------------------------------------------------
// tb_clk_int_div_dyn
//
// Self-checking bench for clk_int_div_dyn (default parameters). A table of
// per-cycle stimulus/expected-output records drives the main scenarios; the
// expected outputs are queued when a record is driven and popped when the DUT
// outputs are sampled 3 time units after the following posedge. Hand-written
// sequences cover reset mid-operation, idle apply, apply-with-stop and an
// edge-to-edge duty measurement at D=5.
// -----------------------------------------------------------------------------
module tb_clk_int_div_dyn;

  localparam int W = 8;

`ifdef CLK_INT_DIV_DYN_ODD_DUTY50_EN
  localparam logic D50 = 1'b1;
`else
  localparam logic D50 = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] div = '0;
  logic         div_valid = 1'b0;
  logic         div_ready;
  logic         div_done;
  logic [W-1:0] clk_cnt;
  logic         clk_out;

  clk_int_div_dyn #(
    .DIV_VALUE_WIDTH(W),
    .DIV_RESET_VALUE(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .div_i      (div),
    .div_valid_i(div_valid),
    .div_ready_o(div_ready),
    .div_done_o (div_done),
    .clk_cnt_o  (clk_cnt),
    .clk_o      (clk_out)
  );

  // Posedges at 10, 30, 50, ...; period 20 time units.
  always #10 clk = ~clk;

  typedef struct {
    logic         en;
    logic         valid;
    logic [W-1:0] div;
    logic         clk;
    logic [W-1:0] cnt;
    logic         rdy;
    logic         done;
  } vec_t;

  typedef struct {
    logic         clk;
    logic [W-1:0] cnt;
    logic         rdy;
    logic         done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input int e, input int v, input int d,
                              input int c, input int n, input int r, input int dn);
    vec_t x;
    x.en    = (e != 0);
    x.valid = (v != 0);
    x.div   = W'(d);
    x.clk   = (c != 0);
    x.cnt   = W'(n);
    x.rdy   = (r != 0);
    x.done  = (dn != 0);
    return x;
  endfunction

  task automatic compareBit(input string name, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic compareCnt(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic compareTime(input string name, input time act, input time req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0t, expected %0t", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    en        = v.en;
    div_valid = v.valid;
    div       = v.div;
    e.clk     = v.clk;
    e.cnt     = v.cnt;
    e.rdy     = v.rdy;
    e.done    = v.done;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got no queued expectation, expected one", name);
      return;
    end
    e = sb.pop_front();
    compareBit({name, ".clk_o"}, clk_out, e.clk);
    compareCnt({name, ".clk_cnt_o"}, clk_cnt, e.cnt);
    compareBit({name, ".div_ready_o"}, div_ready, e.rdy);
    compareBit({name, ".div_done_o"}, div_done, e.done);
  endtask

  // Called at posedge+3: drive, let one posedge pass, sample at posedge+3.
  task automatic step(input string name, input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #3;
    checkOutput(name);
  endtask

  // Poll every 2 units from an odd time, so polls never coincide with the
  // clock or clk_o edges (which all fall on multiples of 10).
  task automatic waitLevel(input logic level, output logic ok, output time t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 300; i++) begin
      if (clk_out === level) begin
        ok = 1'b1;
        t  = $time;
        break;
      end
      #2;
    end
  endtask

  initial begin
    logic ok0, ok1, ok2, ok3;
    time  t_dummy, t0, t1, t2;

    // en, valid, div | clk, cnt, rdy, done
    // Reset release, D=2
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    // Load 5 at cnt=0, applied at the cnt=1 end edge
    vecs.push_back(mk(1, 1, 5, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, D50, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, D50, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4, 1, 0));
    // Load 6 on a period-end edge; applied at the following period end
    vecs.push_back(mk(1, 1, 6, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, D50, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0));
    // Stop requested at cnt=1: period completes, then idle
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    // Restart
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0));
    // Stop cancelled before period end: no gap
    vecs.push_back(mk(0, 0, 0, 0, 4, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    // div=0 -> 2, valid held with 9 while not ready is ignored
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 9, 1, 2, 0, 0));
    vecs.push_back(mk(1, 1, 9, 0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 9, 0, 4, 0, 0));
    vecs.push_back(mk(1, 1, 9, 0, 5, 0, 0));
    vecs.push_back(mk(1, 1, 9, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0));
    // div=1 -> 2, accepted on a period-end edge, applied one period later
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0));
    // Back to D=6, then leave 7 pending during a high phase
    vecs.push_back(mk(1, 1, 6, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 7, 1, 1, 0, 0));

    $display("[TB] start");
    rst = 1'b1;
    @(posedge clk);
    #3;
    @(posedge clk);
    #3;
    compareBit("reset.clk_o", clk_out, 1'b0);
    compareCnt("reset.clk_cnt_o", clk_cnt, '0);
    compareBit("reset.div_ready_o", div_ready, 1'b1);
    compareBit("reset.div_done_o", div_done, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("row%0d", i + 1), vecs[i]);
    end

    // Asynchronous reset in the high phase with 7 pending
    #4;
    rst = 1'b1;
    #1;
    compareBit("midrst.clk_o", clk_out, 1'b0);
    compareCnt("midrst.clk_cnt_o", clk_cnt, '0);
    compareBit("midrst.div_ready_o", div_ready, 1'b1);
    compareBit("midrst.div_done_o", div_done, 1'b0);
    en        = 1'b1;
    div_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Back at D=2 with nothing pending and no done pulse
    step("post_rst1", mk(1, 0, 0, 1, 0, 1, 0));
    step("post_rst2", mk(1, 0, 0, 0, 1, 1, 0));
    step("post_rst3", mk(1, 0, 0, 1, 0, 1, 0));
    step("post_rst4", mk(1, 0, 0, 0, 1, 1, 0));
    step("stop_d2", mk(0, 0, 0, 0, 0, 1, 0));

    // Update while idle is applied on the next posedge
    step("idle_acc", mk(0, 1, 4, 0, 0, 0, 0));
    step("idle_apply", mk(0, 0, 0, 0, 0, 1, 1));
    step("d4_c0", mk(1, 0, 0, 1, 0, 1, 0));
    step("d4_c1", mk(1, 0, 0, 1, 1, 1, 0));
    step("d4_c2", mk(1, 0, 0, 0, 2, 1, 0));
    step("d4_c3", mk(1, 0, 0, 0, 3, 1, 0));
    step("d4_wrap", mk(1, 0, 0, 1, 0, 1, 0));

    // Apply and stop on the same period end; new D used at restart
    step("as_acc", mk(1, 1, 6, 1, 1, 0, 0));
    step("as_c2", mk(0, 0, 0, 0, 2, 0, 0));
    step("as_c3", mk(0, 0, 0, 0, 3, 0, 0));
    step("as_end", mk(0, 0, 0, 0, 0, 1, 1));
    step("as_idle", mk(0, 0, 0, 0, 0, 1, 0));
    step("as_c0", mk(1, 0, 0, 1, 0, 1, 0));
    step("as_c1", mk(1, 0, 0, 1, 1, 1, 0));
    step("as_c2h", mk(1, 0, 0, 1, 2, 1, 0));
    step("as_c3l", mk(1, 0, 0, 0, 3, 1, 0));

    // Load D=5 and measure the duty cycle edge to edge
    step("d5_acc", mk(1, 1, 5, 0, 4, 0, 0));
    step("d5_c5", mk(1, 0, 0, 0, 5, 0, 0));
    step("d5_apply", mk(1, 0, 0, 1, 0, 1, 1));
    div_valid = 1'b0;
    waitLevel(1'b0, ok0, t_dummy);
    waitLevel(1'b1, ok1, t0);
    waitLevel(1'b0, ok2, t1);
    waitLevel(1'b1, ok3, t2);
    if (!(ok0 && ok1 && ok2 && ok3)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL duty_edges: got a missing clk_o edge, expected edges within bound");
    end else begin
      compareTime("duty_high", t1 - t0, D50 ? 50 : 40);
      compareTime("duty_low", t2 - t1, D50 ? 50 : 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
